// File: rtl/citadel_cmd_arb.sv
// Two-requester round-robin arbiter in front of one citadel_fpu command port.
// Granted commands go through a one-entry output stage; responses return to their issuer via a tag FIFO.
module citadel_cmd_arb #(
    parameter int CMD_WIDTH     = 256,
    parameter int RESP_WIDTH    = 32,
    parameter int TAG_DEPTH_POW = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     m0_req_i,
    input  logic [CMD_WIDTH-1:0]     m0_cmd_bi,
    input  logic                     m0_resp_exp_i,
    output logic                     m0_ack_o,
    output logic                     m0_resp_req_o,
    output logic [RESP_WIDTH-1:0]    m0_resp_data_bo,
    input  logic                     m0_resp_ack_i,
    input  logic                     m1_req_i,
    input  logic [CMD_WIDTH-1:0]     m1_cmd_bi,
    input  logic                     m1_resp_exp_i,
    output logic                     m1_ack_o,
    output logic                     m1_resp_req_o,
    output logic [RESP_WIDTH-1:0]    m1_resp_data_bo,
    input  logic                     m1_resp_ack_i,
    output logic                     fpu_req_o,
    output logic [CMD_WIDTH-1:0]     fpu_cmd_bo,
    input  logic                     fpu_ack_i,
    input  logic                     fpu_resp_req_i,
    input  logic [RESP_WIDTH-1:0]    fpu_resp_data_bi,
    output logic                     fpu_resp_ack_o,
    output logic [TAG_DEPTH_POW:0]   outstanding_bo,
    output logic                     err_orphan_o
);

    localparam int DEPTH = 1 << TAG_DEPTH_POW;
    localparam int PW    = TAG_DEPTH_POW + 1;
    localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);

    logic                   ostg_vld_q, ostg_vld_d;
    logic [CMD_WIDTH-1:0]   ostg_cmd_q, ostg_cmd_d;
    logic                   ostg_exp_q, ostg_exp_d;
    logic                   ostg_id_q,  ostg_id_d;
    logic                   prio_q,     prio_d;
    logic [DEPTH-1:0]       tag_q,      tag_d;
    logic [PW-1:0]          wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0]          occ_q,      occ_d;
    logic                   err_q,      err_d;

    logic                   push_s, pop_s, free_s, room_s, empty_s, head_s;
    logic                   elig0_s, elig1_s, gnt0_s, gnt1_s;
    logic [PW:0]            occ_plus_s;

    // Arbitration, output stage, tag FIFO and response routing.
    always_comb begin
        ostg_vld_d      = ostg_vld_q;
        ostg_cmd_d      = ostg_cmd_q;
        ostg_exp_d      = ostg_exp_q;
        ostg_id_d       = ostg_id_q;
        prio_d          = prio_q;
        tag_d           = tag_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        err_d           = err_q;
        gnt0_s          = 1'b0;
        gnt1_s          = 1'b0;
        pop_s           = 1'b0;
        m0_resp_req_o   = 1'b0;
        m1_resp_req_o   = 1'b0;
        m0_resp_data_bo = '0;
        m1_resp_data_bo = '0;
        fpu_resp_ack_o  = 1'b0;

        push_s  = ostg_vld_q && ostg_exp_q && fpu_ack_i;
        free_s  = !ostg_vld_q || fpu_ack_i;
        empty_s = (occ_q == '0);
        head_s  = tag_q[rd_ptr_q[TAG_DEPTH_POW-1:0]];

        // Room check uses pre-pop occupancy plus the tag leaving the output stage now.
        occ_plus_s = {1'b0, occ_q} + {{PW{1'b0}}, push_s};
        room_s     = (occ_plus_s < DEPTH_L);
        elig0_s    = m0_req_i && (!m0_resp_exp_i || room_s);
        elig1_s    = m1_req_i && (!m1_resp_exp_i || room_s);

        if (free_s && !rst_i) begin
            if (!prio_q) begin
                gnt0_s = elig0_s;
                gnt1_s = !elig0_s && elig1_s;
            end else begin
                gnt1_s = elig1_s;
                gnt0_s = !elig1_s && elig0_s;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end

        if (gnt0_s || gnt1_s) begin
            ostg_vld_d = 1'b1;
            ostg_cmd_d = gnt1_s ? m1_cmd_bi : m0_cmd_bi;
            ostg_exp_d = gnt1_s ? m1_resp_exp_i : m0_resp_exp_i;
            ostg_id_d  = gnt1_s;
            prio_d     = gnt0_s;
        end else if (free_s) begin
            ostg_vld_d = 1'b0;
            ostg_cmd_d = '0;
            ostg_exp_d = 1'b0;
            ostg_id_d  = 1'b0;
        end else begin
            ostg_vld_d = ostg_vld_q;
        end

        if (empty_s) begin
            fpu_resp_ack_o = fpu_resp_req_i;
            err_d          = err_q || fpu_resp_req_i;
        end else if (head_s) begin
            m1_resp_req_o   = fpu_resp_req_i;
            m1_resp_data_bo = fpu_resp_data_bi;
            fpu_resp_ack_o  = m1_resp_ack_i;
            pop_s           = fpu_resp_req_i && m1_resp_ack_i;
        end else begin
            m0_resp_req_o   = fpu_resp_req_i;
            m0_resp_data_bo = fpu_resp_data_bi;
            fpu_resp_ack_o  = m0_resp_ack_i;
            pop_s           = fpu_resp_req_i && m0_resp_ack_i;
        end

        if (push_s) begin
            tag_d[wr_ptr_q[TAG_DEPTH_POW-1:0]] = ostg_id_q;
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        occ_d = wr_ptr_d - rd_ptr_d;
    end

    assign m0_ack_o       = gnt0_s;
    assign m1_ack_o       = gnt1_s;
    assign fpu_req_o      = ostg_vld_q;
    assign fpu_cmd_bo     = ostg_cmd_q;
    assign outstanding_bo = occ_q;
    assign err_orphan_o   = err_q;

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ostg_vld_q <= 1'b0;
            ostg_cmd_q <= '0;
            ostg_exp_q <= 1'b0;
            ostg_id_q  <= 1'b0;
            prio_q     <= 1'b0;
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            ostg_vld_q <= ostg_vld_d;
            ostg_cmd_q <= ostg_cmd_d;
            ostg_exp_q <= ostg_exp_d;
            ostg_id_q  <= ostg_id_d;
            prio_q     <= prio_d;
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_citadel_cmd_arb.sv
// Directed vector bench for citadel_cmd_arb: one table row per clock cycle, checked mid-cycle.
module tb_citadel_cmd_arb;

    localparam int CW = 256;
    localparam int RW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           m0_req, m0_exp, m0_ack, m0_rreq, m0_rack;
    logic [CW-1:0]  m0_cmd;
    logic [RW-1:0]  m0_rdata;
    logic           m1_req, m1_exp, m1_ack, m1_rreq, m1_rack;
    logic [CW-1:0]  m1_cmd;
    logic [RW-1:0]  m1_rdata;
    logic           fpu_req, fpu_ack, fpu_rreq, fpu_rack, err;
    logic [CW-1:0]  fpu_cmd;
    logic [RW-1:0]  fpu_rdata;
    logic [3:0]     outst;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    citadel_cmd_arb dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_cmd_bi(m0_cmd), .m0_resp_exp_i(m0_exp), .m0_ack_o(m0_ack),
        .m0_resp_req_o(m0_rreq), .m0_resp_data_bo(m0_rdata), .m0_resp_ack_i(m0_rack),
        .m1_req_i(m1_req), .m1_cmd_bi(m1_cmd), .m1_resp_exp_i(m1_exp), .m1_ack_o(m1_ack),
        .m1_resp_req_o(m1_rreq), .m1_resp_data_bo(m1_rdata), .m1_resp_ack_i(m1_rack),
        .fpu_req_o(fpu_req), .fpu_cmd_bo(fpu_cmd), .fpu_ack_i(fpu_ack),
        .fpu_resp_req_i(fpu_rreq), .fpu_resp_data_bi(fpu_rdata), .fpu_resp_ack_o(fpu_rack),
        .outstanding_bo(outst), .err_orphan_o(err)
    );

    // ef = {m0_ack, m1_ack, fpu_req, m0_resp_req, m1_resp_req, fpu_resp_ack}
    typedef struct packed {
        logic        rst, m0r, m0e, m0a, m1r, m1e, m1a, fa, frr;
        logic [31:0] c0, c1, rd;
        logic [5:0]  ef;
        logic [31:0] ec;
        logic [3:0]  eo;
        logic        ee;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst_v, m0r, m0e, m0a, m1r, m1e, m1a, fa, frr,
                                input logic [31:0] c0, c1, rd, input logic [5:0] ef,
                                input logic [31:0] ec, input int eo, input logic ee);
        vec_t v;
        v.rst = rst_v; v.m0r = m0r; v.m0e = m0e; v.m0a = m0a;
        v.m1r = m1r; v.m1e = m1e; v.m1a = m1a; v.fa = fa; v.frr = frr;
        v.c0 = c0; v.c1 = c1; v.rd = rd; v.ef = ef; v.ec = ec; v.eo = 4'(eo); v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [CW-1:0] got, input logic [CW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] got %0h want %0h", nm, idx, got, want);
        end
    endtask

    initial begin
        vec_t v;
        logic [10:0] obs;
        logic [10:0] exp_obs;

        // single command, resp_exp=0
        vq.push_back(mk(0, 1,0,0, 0,0,0, 1,0, 32'hA5, 32'h0, 32'h0, 6'b100000, 32'h0, 0, 0));
        vq.push_back(mk(0, 0,0,0, 0,0,0, 1,0, 32'h0, 32'h0, 32'h0, 6'b001000, 32'hA5, 0, 0));
        vq.push_back(mk(0, 0,0,0, 0,0,0, 1,0, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 0, 0));
        vq.push_back(mk(1, 0,0,0, 0,0,0, 1,0, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 0, 0));
        // contention: alternate grants starting with m0
        for (int i = 0; i < 8; i++)
            vq.push_back(mk(0, 1,0,0, 1,0,0, 1,0, 32'h10, 32'h20, 32'h0,
                            {(i % 2 == 0), (i % 2 == 1), (i > 0), 3'b000},
                            (i % 2 == 1) ? 32'h10 : 32'h20, 0, 0));
        // stall with ostg holding m1's command
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(0, 1,0,0, 1,0,0, 0,0, 32'h10, 32'h20, 32'h0, 6'b001000, 32'h20, 0, 0));
        vq.push_back(mk(0, 1,0,0, 1,0,0, 1,0, 32'h10, 32'h20, 32'h0, 6'b101000, 32'h20, 0, 0));
        vq.push_back(mk(0, 0,0,0, 0,0,0, 1,0, 32'h0, 32'h0, 32'h0, 6'b001000, 32'h10, 0, 0));
        vq.push_back(mk(0, 0,0,0, 0,0,0, 1,0, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 0, 0));
        // routing: m1 then m0 issue resp_exp commands
        vq.push_back(mk(0, 0,0,0, 1,1,0, 1,0, 32'h0, 32'h31, 32'h0, 6'b010000, 32'h0, 0, 0));
        vq.push_back(mk(0, 1,1,0, 0,0,0, 1,0, 32'h30, 32'h0, 32'h0, 6'b101000, 32'h31, 0, 0));
        vq.push_back(mk(0, 0,0,0, 0,0,0, 1,0, 32'h0, 32'h0, 32'h0, 6'b001000, 32'h30, 1, 0));
        vq.push_back(mk(0, 0,0,0, 0,0,0, 1,0, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 2, 0));
        vq.push_back(mk(0, 0,0,0, 0,0,1, 1,1, 32'h0, 32'h0, 32'h11111111, 6'b000011, 32'h0, 2, 0));
        vq.push_back(mk(0, 0,0,0, 0,0,1, 1,1, 32'h0, 32'h0, 32'h22222222, 6'b000100, 32'h0, 1, 0));
        vq.push_back(mk(0, 0,0,1, 0,0,0, 1,1, 32'h0, 32'h0, 32'h22222222, 6'b000101, 32'h0, 1, 0));
        vq.push_back(mk(0, 0,0,0, 0,0,0, 1,0, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 0, 0));
        // fill the tag FIFO with 8 resp_exp commands
        for (int k = 1; k <= 8; k++)
            vq.push_back(mk(0, 1,1,0, 0,0,0, 1,0, 32'h40, 32'h0, 32'h0, {2'b10, (k > 1), 3'b000},
                            32'h40, (k > 2) ? k - 2 : 0, 0));
        vq.push_back(mk(0, 1,1,0, 1,0,0, 1,0, 32'h41, 32'h50, 32'h0, 6'b011000, 32'h40, 7, 0));
        // m0 holds priority but is blocked on a full FIFO; m1 resp_exp=0 flows
        vq.push_back(mk(0, 1,1,0, 1,0,0, 1,0, 32'h41, 32'h51, 32'h0, 6'b011000, 32'h50, 8, 0));
        vq.push_back(mk(0, 1,1,0, 0,0,0, 1,0, 32'h41, 32'h0, 32'h0, 6'b001000, 32'h51, 8, 0));
        vq.push_back(mk(0, 1,1,1, 0,0,0, 1,1, 32'h41, 32'h0, 32'hCAFE0001, 6'b000101, 32'h0, 8, 0));
        vq.push_back(mk(0, 1,1,0, 0,0,0, 1,0, 32'h41, 32'h0, 32'h0, 6'b100000, 32'h0, 7, 0));
        vq.push_back(mk(0, 0,0,0, 0,0,0, 1,0, 32'h0, 32'h0, 32'h0, 6'b001000, 32'h41, 7, 0));
        vq.push_back(mk(0, 0,0,0, 0,0,0, 1,0, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 8, 0));
        // reset, then orphan response
        vq.push_back(mk(1, 0,0,0, 0,0,0, 1,0, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 8, 0));
        vq.push_back(mk(0, 0,0,0, 0,0,0, 1,1, 32'h0, 32'h0, 32'hDEAD, 6'b000001, 32'h0, 0, 0));
        vq.push_back(mk(0, 0,0,0, 0,0,0, 1,0, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 0, 1));
        vq.push_back(mk(0, 0,0,0, 0,0,0, 1,0, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 0, 1));
        // build 3 outstanding plus a valid ostg, then reset mid-operation
        for (int j = 0; j < 4; j++)
            vq.push_back(mk(0, 0,0,0, 1,1,0, 1,0, 32'h0, 32'h60, 32'h0, {2'b01, (j > 0), 3'b000},
                            32'h60, (j > 1) ? j - 1 : 0, 1));
        vq.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 32'h0, 32'h0, 32'h0, 6'b001000, 32'h60, 3, 1));
        vq.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 32'h0, 32'h0, 32'h0, 6'b001000, 32'h60, 3, 1));
        vq.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 0, 0));

        rst = 1'b1; m0_req = 1'b0; m0_exp = 1'b0; m0_rack = 1'b0; m0_cmd = '0;
        m1_req = 1'b0; m1_exp = 1'b0; m1_rack = 1'b0; m1_cmd = '0;
        fpu_ack = 1'b0; fpu_rreq = 1'b0; fpu_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_ctl", 0, {m0_ack, m1_ack, fpu_req, m0_rreq, m1_rreq, fpu_rack, outst, err}, '0);
        chk("reset_cmd", 0, fpu_cmd, '0);

        for (int n = 0; n < vq.size(); n++) begin
            v = vq[n];
            @(negedge clk);
            rst = v.rst; m0_req = v.m0r; m0_exp = v.m0e; m0_rack = v.m0a;
            m1_req = v.m1r; m1_exp = v.m1e; m1_rack = v.m1a;
            fpu_ack = v.fa; fpu_rreq = v.frr; fpu_rdata = v.rd;
            m0_cmd = {8{v.c0}}; m1_cmd = {8{v.c1}};
            #1;
            obs     = {m0_ack, m1_ack, fpu_req, m0_rreq, m1_rreq, fpu_rack, outst, err};
            exp_obs = {v.ef, v.eo, v.ee};
            chk("ctl", n, {245'h0, obs}, {245'h0, exp_obs});
            if (v.ef[3]) chk("cmd", n, fpu_cmd, {8{v.ec}});
            if (v.ef[2]) chk("m0_data", n, {224'h0, m0_rdata}, {224'h0, v.rd});
            if (v.ef[1]) chk("m1_data", n, {224'h0, m1_rdata}, {224'h0, v.rd});
        end

        // after the mid-operation reset every output must be zero
        #1;
        chk("post_rst_cmd", 0, fpu_cmd, '0);
        chk("post_rst_data", 0, {192'h0, m0_rdata, m1_rdata}, '0);

        // orphan flag stays clear after reset even with a fresh orphan-free cycle
        @(negedge clk);
        fpu_ack = 1'b1;
        #1;
        chk("post_rst_err", 0, {255'h0, err}, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
